// File: rtl/coord_jog_ctrl_if.sv
// Button, axis-select and coordinate signals between the jog controller and
// its surroundings (button pins on one side, servo PWM stage on the other).
interface coord_jog_if #(
    parameter int BIT_SIZE = 10
);
    logic                       btn_inc;
    logic                       btn_dec;
    logic                       btn_home;
    logic [1:0]                 axis_sel;
    logic signed [BIT_SIZE-1:0] x;
    logic signed [BIT_SIZE-1:0] y;
    logic signed [BIT_SIZE-1:0] z;
    logic                       step_pulse;
    logic                       at_limit;

    modport master (
        output btn_inc, btn_dec, btn_home, axis_sel,
        input  x, y, z, step_pulse, at_limit
    );

    modport slave (
        input  btn_inc, btn_dec, btn_home, axis_sel,
        output x, y, z, step_pulse, at_limit
    );
endinterface

// File: rtl/coord_jog_ctrl.sv
// Push-button jog controller: synchronises and debounces inc/dec/home buttons
// and steps the selected x/y/z coordinate with auto-repeat and saturation.
module coord_jog_ctrl #(
    parameter int FREQ               = 25_000_000,
    parameter int BIT_SIZE           = 10,
    parameter int INVERT_INC         = 1,
    parameter int INVERT_DEC         = 1,
    parameter int INVERT_HOME        = 0,
    parameter int DEBOUNCE_THRESHOLD = 5000,
    parameter int STEP               = 10,
    parameter int COORD_MIN          = -270,
    parameter int COORD_MAX          = 270,
    parameter int COORD_HOME         = 90,
    parameter int REPEAT_DELAY       = 12_500_000,
    parameter int REPEAT_RATE        = 2_500_000
) (
    input logic        clk,
    input logic        rst,
    coord_jog_if.slave bus
);

    localparam int EXT_W   = BIT_SIZE + 2;
    localparam int DB_W    = $clog2(DEBOUNCE_THRESHOLD + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    localparam int B_INC  = 0;
    localparam int B_DEC  = 1;
    localparam int B_HOME = 2;

    localparam logic [2:0]      INV_MASK   = {1'(INVERT_HOME), 1'(INVERT_DEC), 1'(INVERT_INC)};
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_THRESHOLD - 1);
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

    localparam logic signed [BIT_SIZE-1:0] HOME_V = BIT_SIZE'(COORD_HOME);
    localparam logic signed [BIT_SIZE-1:0] MIN_V  = BIT_SIZE'(COORD_MIN);
    localparam logic signed [BIT_SIZE-1:0] MAX_V  = BIT_SIZE'(COORD_MAX);
    localparam logic signed [EXT_W-1:0]    LIM_LO = EXT_W'(COORD_MIN);
    localparam logic signed [EXT_W-1:0]    LIM_HI = EXT_W'(COORD_MAX);
    localparam logic signed [EXT_W-1:0]    STEP_X = EXT_W'(STEP);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    if (FREQ < 1 || DEBOUNCE_THRESHOLD < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1
        || COORD_MIN > COORD_MAX) begin : g_param_check
        $error("coord_jog_ctrl: invalid parameter set");
    end

    // Widen before adding so the clamp sees the true sum even near the rails.
    function automatic logic signed [BIT_SIZE-1:0] step_sat(
        input logic signed [BIT_SIZE-1:0] cur,
        input logic                       up
    );
        logic signed [EXT_W-1:0] sum;
        sum = {{2{cur[BIT_SIZE-1]}}, cur};
        sum = up ? (sum + STEP_X) : (sum - STEP_X);
        if (sum > LIM_HI) begin
            sum = LIM_HI;
        end else if (sum < LIM_LO) begin
            sum = LIM_LO;
        end
        return sum[BIT_SIZE-1:0];
    endfunction

    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [2:0]      deb_q, deb_d;
    logic [2:0]      deb_prev_q, deb_prev_d;
    logic [2:0]      arm_q, arm_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    logic [1:0]                 state_q, state_d;
    logic                       dir_q, dir_d;
    logic [RC_W-1:0]            rcnt_q, rcnt_d;
    logic signed [BIT_SIZE-1:0] x_q, x_d;
    logic signed [BIT_SIZE-1:0] y_q, y_d;
    logic signed [BIT_SIZE-1:0] z_q, z_d;
    logic                       pulse_q, pulse_d;

    logic [2:0]                 lvl;
    logic [2:0]                 press;
    logic                       axis_valid;
    logic                       release_jog;
    logic                       do_step;
    logic                       step_up;
    logic signed [BIT_SIZE-1:0] sel_cur;
    logic signed [BIT_SIZE-1:0] next_v;

    assign sync1_d    = {bus.btn_home, bus.btn_dec, bus.btn_inc};
    assign sync2_d    = sync1_q;
    assign lvl        = sync2_q ^ INV_MASK;
    assign deb_prev_d = deb_q;
    // A press only counts once the button has been seen released since reset.
    assign arm_d      = arm_q | ~lvl;
    assign press      = deb_q & ~deb_prev_q & arm_q;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (lvl[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = lvl[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign axis_valid = (bus.axis_sel != 2'd3);

    always_comb begin
        case (bus.axis_sel)
            2'd0:    sel_cur = x_q;
            2'd1:    sel_cur = y_q;
            2'd2:    sel_cur = z_q;
            default: sel_cur = x_q;
        endcase
    end

    assign release_jog = dir_q ? (!deb_q[B_INC] || deb_q[B_DEC])
                               : (!deb_q[B_DEC] || deb_q[B_INC]);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rcnt_d  = rcnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        pulse_d = 1'b0;
        do_step = 1'b0;
        step_up = dir_q;
        next_v  = sel_cur;
        if (press[B_HOME]) begin
            x_d     = HOME_V;
            y_d     = HOME_V;
            z_d     = HOME_V;
            pulse_d = 1'b1;
            state_d = S_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press[B_INC] && !deb_q[B_DEC]) begin
                        do_step = 1'b1;
                        step_up = 1'b1;
                        dir_d   = 1'b1;
                        state_d = S_HOLD;
                        rcnt_d  = '0;
                    end else if (press[B_DEC] && !deb_q[B_INC]) begin
                        do_step = 1'b1;
                        step_up = 1'b0;
                        dir_d   = 1'b0;
                        state_d = S_HOLD;
                        rcnt_d  = '0;
                    end
                end
                S_HOLD: begin
                    if (release_jog) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == DELAY_LAST) begin
                        do_step = 1'b1;
                        state_d = S_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (release_jog) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RATE_LAST) begin
                        do_step = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rcnt_d  = '0;
                end
            endcase
            next_v = step_sat(sel_cur, step_up);
            // Steps that would not move the axis (rail reached, no axis) are silent.
            if (do_step && axis_valid && (next_v != sel_cur)) begin
                pulse_d = 1'b1;
                case (bus.axis_sel)
                    2'd0:    x_d = next_v;
                    2'd1:    y_d = next_v;
                    default: z_d = next_v;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= ~INV_MASK;
            sync2_q    <= ~INV_MASK;
            deb_q      <= '0;
            deb_prev_q <= '0;
            arm_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            rcnt_q     <= '0;
            x_q        <= HOME_V;
            y_q        <= HOME_V;
            z_q        <= HOME_V;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            arm_q      <= arm_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q    <= state_d;
            dir_q      <= dir_d;
            rcnt_q     <= rcnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            pulse_q    <= pulse_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.z          = z_q;
    assign bus.step_pulse = pulse_q;
    assign bus.at_limit   = axis_valid && ((sel_cur == MIN_V) || (sel_cur == MAX_V));

endmodule
